dk_motion: RTL

Per-frame motion and animation controller for the Donkey Kong sprite. It produces the sprite position (`curr_h`, `curr_v`), pose select (`sprite_selec`) and draw enable (`bounds_draw`) that the sprite draw stage consumes. Internal state advances exactly once per video frame, on a tick derived from the VGA `hcount`/`vcount` counters. The sprite patrols horizontally with edge pauses, and a req/ack handshake lets game logic request a barrel throw.

---
 rtl/dk_motion_if.sv | 23 ++
 rtl/dk_motion.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dk_motion_if.sv
// Sprite motion bundle: raster counters and game controls in,
// sprite position/pose/draw and throw acknowledge out.
interface dk_motion_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       en;
    logic       throw_req;
    logic [9:0] curr_h;
    logic [9:0] curr_v;
    logic [1:0] sprite_selec;
    logic       bounds_draw;
    logic       throw_ack;

    modport master (
        output hcount, vcount, en, throw_req,
        input  curr_h, curr_v, sprite_selec, bounds_draw, throw_ack
    );

    modport slave (
        input  hcount, vcount, en, throw_req,
        output curr_h, curr_v, sprite_selec, bounds_draw, throw_ack
    );
endinterface

// File: rtl/dk_motion.sv
// Donkey Kong sprite controller: patrols with edge pauses and throws
// barrels on request; all state advances once per raster frame tick.
module dk_motion #(
    parameter int H_MIN        = 32,
    parameter int H_MAX        = 544,
    parameter int H_START      = 32,
    parameter int V_POS        = 40,
    parameter int STEP         = 2,
    parameter int ANIM_FRAMES  = 8,
    parameter int PAUSE_FRAMES = 30,
    parameter int THROW_FRAMES = 16,
    parameter int TICK_H       = 0,
    parameter int TICK_V       = 480
) (
    input  logic       clk,
    input  logic       rst,
    dk_motion_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WALK_R, WALK_L, PAUSE, THROW
    } state_t;

    state_t      state_q;
    logic [9:0]  h_q;
    logic [1:0]  sel_q;
    logic        draw_q;
    logic        ack_q;
    logic        dir_q;
    logic        armed_q;
    logic        resume_pause_q;
    logic [15:0] anim_q;
    logic [15:0] frm_q;
    logic        match_q;
    logic        match_qq;

    logic               match;
    logic               tick;
    logic               walking;
    logic               can_throw;
    logic               anim_wrap;
    logic [10:0]        h_sum;
    logic signed [11:0] h_diff;
    logic [9:0]         h_right_d;
    logic [9:0]         h_left_d;

    assign match = (bus.hcount == 10'(TICK_H)) &&
                   (bus.vcount == 10'(TICK_V));
    // Edge detect so a raster point held for several clks ticks once
    assign tick = match_q & ~match_qq;

    assign walking = (state_q == WALK_R) || (state_q == WALK_L);
    assign can_throw = (walking || (state_q == PAUSE)) &&
                       bus.throw_req && armed_q;
    assign anim_wrap = (anim_q == 16'(ANIM_FRAMES - 1));

    assign h_sum = {1'b0, h_q} + 11'(STEP);
    assign h_diff = $signed({2'b00, h_q}) - $signed(12'(STEP));
    assign h_right_d = (h_sum >= 11'(H_MAX)) ? 10'(H_MAX) : h_sum[9:0];
    assign h_left_d = (h_diff <= $signed(12'(H_MIN))) ?
                      10'(H_MIN) : h_diff[9:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            h_q            <= 10'(H_START);
            sel_q          <= 2'b00;
            draw_q         <= 1'b0;
            ack_q          <= 1'b0;
            dir_q          <= 1'b0;
            armed_q        <= 1'b1;
            resume_pause_q <= 1'b0;
            anim_q         <= '0;
            frm_q          <= '0;
            match_q        <= 1'b0;
            match_qq       <= 1'b0;
        end else begin
            match_q  <= match;
            match_qq <= match_q;
            ack_q    <= 1'b0;
            if (tick) begin
                if (!bus.throw_req) armed_q <= 1'b1;
                if (!bus.en) begin
                    state_q <= IDLE;
                    sel_q   <= 2'b00;
                    draw_q  <= 1'b0;
                end else if (can_throw) begin
                    state_q        <= THROW;
                    frm_q          <= '0;
                    armed_q        <= 1'b0;
                    resume_pause_q <= (state_q == PAUSE);
                    sel_q          <= 2'b01;
                end else begin
                    unique case (state_q)
                        IDLE: begin
                            state_q <= dir_q ? WALK_L : WALK_R;
                            anim_q  <= '0;
                            sel_q   <= 2'b00;
                            draw_q  <= 1'b1;
                        end
                        WALK_R: begin
                            h_q <= h_right_d;
                            if (h_right_d == 10'(H_MAX)) begin
                                state_q <= PAUSE;
                                dir_q   <= 1'b1;
                                frm_q   <= '0;
                                sel_q   <= 2'b00;
                            end else if (anim_wrap) begin
                                anim_q <= '0;
                                sel_q  <= sel_q ^ 2'b01;
                            end else begin
                                anim_q <= anim_q + 16'd1;
                            end
                        end
                        WALK_L: begin
                            h_q <= h_left_d;
                            if (h_left_d == 10'(H_MIN)) begin
                                state_q <= PAUSE;
                                dir_q   <= 1'b0;
                                frm_q   <= '0;
                                sel_q   <= 2'b00;
                            end else if (anim_wrap) begin
                                anim_q <= '0;
                                sel_q  <= sel_q ^ 2'b01;
                            end else begin
                                anim_q <= anim_q + 16'd1;
                            end
                        end
                        PAUSE: begin
                            if (frm_q == 16'(PAUSE_FRAMES - 1)) begin
                                state_q <= dir_q ? WALK_L : WALK_R;
                                anim_q  <= '0;
                                sel_q   <= 2'b00;
                            end else begin
                                frm_q <= frm_q + 16'd1;
                            end
                        end
                        THROW: begin
                            if (frm_q == 16'(THROW_FRAMES - 1)) begin
                                ack_q <= 1'b1;
                                sel_q <= 2'b00;
                                frm_q <= '0;
                                anim_q <= '0;
                                if (resume_pause_q) state_q <= PAUSE;
                                else state_q <= dir_q ? WALK_L : WALK_R;
                            end else begin
                                frm_q <= frm_q + 16'd1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.curr_h       = h_q;
    assign bus.curr_v       = 10'(V_POS);
    assign bus.sprite_selec = sel_q;
    assign bus.bounds_draw  = draw_q;
    assign bus.throw_ack    = ack_q;
endmodule
